pipe_front_regs: RTL and testbench
==================================

Name: pipe_front_regs

Overview:
- Implements the PC register, the IF/ID pipeline register and the ID/EX pipeline register of the 5-stage core.
- It is the consumer of the hazard unit's StallF/StallD/FlushD/FlushE controls. It applies them cycle-accurately and inserts bubbles.
- Carries valid bits so downstream stages can ignore bubbles.
- Holds saturating stall/flush event counters for performance debug.

Parameters:
- XLEN, 32, datapath/PC width
- RESET_PC, 32'h0000_0000, PCF value after reset
- NOP_INSTR, 32'h0000_0013, instruction word loaded into InstrD on flush or reset (addi x0,x0,0)
- CNT_W, 16, width of the event counters

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous active-high reset
- StallF  in  1  hold PCF
- StallD  in  1  hold IF/ID
- FlushD  in  1  clear IF/ID to bubble
- FlushE  in  1  clear ID/EX to bubble
- PCSrcE  in  1  redirect fetch to PCTargetE
- PCTargetE  in  XLEN  branch/jump target from E
- InstrF  in  32  instruction memory read data for PCF
- PCF  out  XLEN  fetch address
- InstrD, PCD, PCPlus4D  out  32/XLEN/XLEN  IF/ID contents
- ValidD  out  1  IF/ID holds a real instruction
- Rs1D, Rs2D, RdD  in  5 each  decoded register indices
- RD1D, RD2D, ImmExtD  in  XLEN each  register file data and immediate
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode controls
- ResultSrcD  in  2  decode control
- ALUControlD  in  3  decode control
- Rs1E, Rs2E, RdE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  ID/EX data copies
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE  out  ID/EX control copies
- ValidE  out  1  ID/EX holds a real instruction
- stall_cnt  out  CNT_W  cycles with StallD=1
- flush_cnt  out  CNT_W  cycles with FlushD=1 or FlushE=1

Behaviour:
Reset (async, takes effect immediately, independent of clk):
- PCF=RESET_PC.
- InstrD=NOP_INSTR; PCD=0; PCPlus4D=0; ValidD=0.
- All E outputs=0; ValidE=0.
- stall_cnt=0; flush_cnt=0.
- Reset asserted mid-operation discards all in-flight state. The first fetch after release is RESET_PC.

PC register, per rising edge:
- PCSrcE=1: PCF<=PCTargetE. Redirect wins over StallF.
- else StallF=1: hold.
- else: PCF<=PCF+4, modulo 2^XLEN; 0xFFFF_FFFC wraps to 0.

IF/ID register, per edge, in priority order:
1. FlushD=1: bubble. InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0. FlushD wins over StallD.
2. StallD=1: hold all fields, including ValidD.
3. Otherwise: InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1.

ID/EX register, per edge:
- FlushE=1: every E output, including Rs1E/Rs2E/RdE, goes to 0, and ValidE goes to 0. A zero RdE and RegWriteE=0 guarantees that bubbles never cause forwarding or load-use stalls.
- Otherwise: capture all D inputs, plus PCE<=PCD and PCPlus4E<=PCPlus4D, and ValidE<=ValidD.
- ID/EX has no stall input. A load-use stall is expressed only as StallF+StallD+FlushE.

Simultaneous controls:
- StallD=1 with FlushE=1 (load-use): the instruction in D is held, and a bubble enters E.
- FlushD=1 with FlushE=1 (taken branch): both stages become bubbles, and PCF takes the target.
- All four stall/flush controls=1: flush behaviour applies to D and E; PC follows the PCSrcE rule.

Counters:
- stall_cnt increments by 1 on each edge where StallD=1.
- flush_cnt increments by 1 on each edge where FlushD|FlushE=1.
- Both saturate at 2^CNT_W-1 and never wrap.

Latency:
- One cycle per register.
- All outputs come directly from flops. There is no combinational path from any input to any output.

Test Plan:
- Reset then 3 free-run cycles, InstrF=0x00500093 constant -> PCF=0,4,8,C. After cycle 1: InstrD=0x00500093, PCD=0, ValidD=1. ValidE=1 one cycle later.
- Load-use: StallF=StallD=FlushE=1 for 1 cycle at PCF=0x10 -> PCF stays 0x10; InstrD/PCD unchanged; ValidE=0, RdE=0, RegWriteE=0; stall_cnt=1, flush_cnt=1.
- Taken branch: PCSrcE=FlushD=FlushE=1, PCTargetE=0x200 -> next PCF=0x200; InstrD=0x00000013, ValidD=0, ValidE=0; the cycle after, PCD=0x200.
- Priority: StallF=StallD=FlushD=1, PCSrcE=1, PCTargetE=0x40 -> PCF=0x40, ValidD=0 (flush and redirect win).
- Wrap and saturate: PCF forced near top via PCTargetE=0xFFFF_FFFC, then free-run -> PCF=0. StallD held high 70000 cycles with CNT_W=16 -> stall_cnt=0xFFFF and holds.
- Async reset asserted between edges mid-stall -> outputs go to reset values before the next edge; after release, PCF=RESET_PC and both counters are 0.

Source files
------------

// File: rtl/pipe_front_regs.sv
// PC register plus IF/ID and ID/EX pipeline registers for the 5-stage core.
// Applies hazard-unit stall/flush controls, tracks valid bits and counts stall/flush events.
module pipe_front_regs #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  input  logic             PCSrcE,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic [31:0]      InstrF,
  output logic [XLEN-1:0]  PCF,
  output logic [31:0]      InstrD,
  output logic [XLEN-1:0]  PCD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic             ValidD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       ALUControlD,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic [1:0]       ResultSrcE,
  output logic [2:0]       ALUControlE,
  output logic             ValidE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0]  PC_RST   = XLEN'(RESET_PC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [XLEN-1:0] pc_plus4_f;
  logic [XLEN-1:0] pc_next;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pc_plus4_f = PCF + PC_STEP;
    pc_next    = PCF;
    if (PCSrcE)       pc_next = PCTargetE;
    else if (!StallF) pc_next = pc_plus4_f;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) PCF <= PC_RST;
    else     PCF <= pc_next;
  end

  // FlushD outranks StallD: a squashed instruction must never be held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= pc_plus4_f;
      ValidD   <= 1'b1;
    end
  end

  // Bubbles zero RdE and RegWriteE so they can never trigger forwarding or load-use detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || FlushE) begin
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      ValidE      <= 1'b0;
    end else begin
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      ImmExtE     <= ImmExtD;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      RegWriteE   <= RegWriteD;
      MemWriteE   <= MemWriteD;
      JumpE       <= JumpD;
      BranchE     <= BranchD;
      ALUSrcE     <= ALUSrcD;
      ResultSrcE  <= ResultSrcD;
      ALUControlE <= ALUControlD;
      ValidE      <= ValidD;
    end
  end

  // Saturating event counters for performance debug.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallD && stall_cnt != CNT_MAX)              stall_cnt <= stall_cnt + CNT_ONE;
      if ((FlushD || FlushE) && flush_cnt != CNT_MAX)  flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_front_regs.sv
// Self-checking bench for pipe_front_regs: a per-cycle reference model plus
// hand-computed expectations for reset, load-use, branch, priority, wrap, saturation and async reset.
module tb_pipe_front_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, FlushE, PCSrcE;
  logic [31:0] PCTargetE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [31:0] RD1D, RD2D, ImmExtD;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic        ValidE;
  logic [15:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  pipe_front_regs dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .ValidE(ValidE), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural contents of each stage, updated by the stated rules.
  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic        regw, memw, jump, branch, alusrc;
    logic [1:0]  ressrc;
    logic [2:0]  aluctl;
    logic        valid;
  } e_stage_t;

  logic [31:0] m_pcf, m_instrd, m_pcd, m_pc4d;
  logic        m_validd;
  e_stage_t    m_e;
  int          m_stall, m_flush;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pcf = 32'h0; m_instrd = 32'h13; m_pcd = 0; m_pc4d = 0; m_validd = 0;
      m_e = '0; m_stall = 0; m_flush = 0;
    end else begin
      if (FlushE) m_e = '0;
      else m_e = '{rs1: Rs1D, rs2: Rs2D, rd: RdD, rd1: RD1D, rd2: RD2D, imm: ImmExtD,
                   pc: m_pcd, pc4: m_pc4d, regw: RegWriteD, memw: MemWriteD, jump: JumpD,
                   branch: BranchD, alusrc: ALUSrcD, ressrc: ResultSrcD,
                   aluctl: ALUControlD, valid: m_validd};
      if (FlushD) begin
        m_instrd = 32'h13; m_pcd = 0; m_pc4d = 0; m_validd = 0;
      end else if (!StallD) begin
        m_instrd = InstrF; m_pcd = m_pcf; m_pc4d = m_pcf + 32'd4; m_validd = 1;
      end
      if (PCSrcE)       m_pcf = PCTargetE;
      else if (!StallF) m_pcf = m_pcf + 32'd4;
      if (StallD)           m_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
      if (FlushD || FlushE) m_flush = (m_flush + 1 > 65535) ? 65535 : m_flush + 1;
    end
  end

  // Compare process: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    check("PCF", PCF, m_pcf);
    check("InstrD", InstrD, m_instrd);
    check("PCD", PCD, m_pcd);
    check("PCPlus4D", PCPlus4D, m_pc4d);
    check("ValidD", ValidD, m_validd);
    check("Rs1E", Rs1E, m_e.rs1);
    check("Rs2E", Rs2E, m_e.rs2);
    check("RdE", RdE, m_e.rd);
    check("RD1E", RD1E, m_e.rd1);
    check("RD2E", RD2E, m_e.rd2);
    check("ImmExtE", ImmExtE, m_e.imm);
    check("PCE", PCE, m_e.pc);
    check("PCPlus4E", PCPlus4E, m_e.pc4);
    check("E_ctrl", {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE},
          {m_e.regw, m_e.memw, m_e.jump, m_e.branch, m_e.alusrc, m_e.ressrc, m_e.aluctl});
    check("ValidE", ValidE, m_e.valid);
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl(input logic sf, input logic sd, input logic fd, input logic fe,
                      input logic ps, input logic [31:0] tgt);
    StallF = sf; StallD = sd; FlushD = fd; FlushE = fe; PCSrcE = ps; PCTargetE = tgt;
  endtask

  task automatic d_inputs(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic [31:0] base, input logic [9:0] ctl);
    Rs1D = r1; Rs2D = r2; RdD = rd;
    RD1D = base; RD2D = base ^ 32'hA5A5_0000; ImmExtD = base + 32'd7;
    {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD} = ctl;
  endtask

  initial begin
    rst = 1'b1;
    ctrl(0, 0, 0, 0, 0, 32'h0);
    InstrF = 32'h0050_0093;
    d_inputs(5'd1, 5'd2, 5'd5, 32'h1111_0000, 10'b10000_01_010);
    repeat (2) @(posedge clk);
    #1;
    check("rst_PCF", PCF, 32'h0);
    check("rst_InstrD", InstrD, 32'h13);
    check("rst_ValidD", ValidD, 1'b0);
    check("rst_ValidE", ValidE, 1'b0);
    rst = 1'b0;

    // Free run: PCF 0,4,8,C
    step();
    check("run1_PCF", PCF, 32'h4);
    check("run1_InstrD", InstrD, 32'h0050_0093);
    check("run1_PCD", PCD, 32'h0);
    check("run1_ValidD", ValidD, 1'b1);
    step();
    check("run2_PCF", PCF, 32'h8);
    check("run2_ValidE", ValidE, 1'b1);
    step();
    check("run3_PCF", PCF, 32'hC);
    step();
    check("run4_PCF", PCF, 32'h10);

    // Load-use stall at PCF=0x10
    ctrl(1, 1, 0, 1, 0, 32'h0);
    step();
    check("lu_PCF", PCF, 32'h10);
    check("lu_PCD", PCD, 32'hC);
    check("lu_InstrD", InstrD, 32'h0050_0093);
    check("lu_ValidE", ValidE, 1'b0);
    check("lu_RdE", RdE, 5'd0);
    check("lu_RegWriteE", RegWriteE, 1'b0);
    check("lu_stall_cnt", stall_cnt, 16'd1);
    check("lu_flush_cnt", flush_cnt, 16'd1);
    ctrl(0, 0, 0, 0, 0, 32'h0);
    step();
    check("lu_after_RdE", RdE, 5'd5);
    check("lu_after_PCE", PCE, 32'hC);

    // Taken branch
    InstrF = 32'h0020_8133;
    ctrl(0, 0, 1, 1, 1, 32'h200);
    step();
    check("br_PCF", PCF, 32'h200);
    check("br_InstrD", InstrD, 32'h13);
    check("br_ValidD", ValidD, 1'b0);
    check("br_ValidE", ValidE, 1'b0);
    ctrl(0, 0, 0, 0, 0, 32'h0);
    step();
    check("br_next_PCD", PCD, 32'h200);
    check("br_next_PCF", PCF, 32'h204);
    step();

    // All controls asserted with redirect
    ctrl(1, 1, 1, 1, 1, 32'h40);
    step();
    check("pri_PCF", PCF, 32'h40);
    check("pri_ValidD", ValidD, 1'b0);
    check("pri_ValidE", ValidE, 1'b0);
    ctrl(1, 1, 1, 0, 1, 32'h80);
    step();
    check("pri2_PCF", PCF, 32'h80);
    check("pri2_ValidD", ValidD, 1'b0);

    // PC wrap
    ctrl(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step();
    check("wrap_top_PCF", PCF, 32'hFFFF_FFFC);
    ctrl(0, 0, 0, 0, 0, 32'h0);
    step();
    check("wrap_PCF", PCF, 32'h0);
    check("wrap_PCPlus4D", PCPlus4D, 32'h0);

    // Directed vectors through D inputs and mixed controls
    for (int i = 0; i < 6; i++) begin
      d_inputs(5'(i + 3), 5'(31 - i), 5'(i * 5), 32'h0BAD_0000 + 32'(i), 10'(i * 97));
      InstrF = 32'h0000_0033 + 32'(i << 7);
      ctrl(i[0], i[1], 1'b0, i == 4, 1'b0, 32'h0);
      step();
    end
    ctrl(0, 0, 0, 0, 0, 32'h0);
    step();

    // Counter saturation
    ctrl(0, 1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 70000; i++) begin
      InstrF = 32'(i);
      step();
    end
    check("sat_stall_cnt", stall_cnt, 16'hFFFF);
    step();
    check("sat_hold_stall_cnt", stall_cnt, 16'hFFFF);

    // Async reset mid-stall, between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_PCF", PCF, 32'h0);
    check("arst_InstrD", InstrD, 32'h13);
    check("arst_ValidD", ValidD, 1'b0);
    check("arst_stall_cnt", stall_cnt, 16'h0);
    check("arst_flush_cnt", flush_cnt, 16'h0);
    ctrl(0, 0, 0, 0, 0, 32'h0);
    InstrF = 32'h0050_0093;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rel_PCF", PCF, 32'h0);
    step();
    check("rel_PCD", PCD, 32'h0);
    check("rel_PCF_next", PCF, 32'h4);
    check("rel_stall_cnt", stall_cnt, 16'h0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
